// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake, flags and occupancy of sync_fifo.
// FIFO_ERR_FLAGS_EN adds the overflow/underflow error pulses.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
   logic                  overflow;
   logic                  underflow;
`endif

   modport master (
      output wr_en, wr_data, rd_en,
      input  full, rd_data, empty, count
`ifdef FIFO_ERR_FLAGS_EN
      , input overflow, underflow
`endif
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output full, rd_data, empty, count
`ifdef FIFO_ERR_FLAGS_EN
      , output overflow, underflow
`endif
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of 2^ADDR_WIDTH words with registered read data.
// Define FIFO_ERR_FLAGS_EN to add registered overflow/underflow pulses.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input logic      clk,
   input logic      rst_n,
   sync_fifo_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   // Extra wrap bit distinguishes full from empty when the indices match.
   assign w_empty  = r_wr_ptr == r_rd_ptr;
   assign w_full   = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
   assign w_wr_acc = bus.wr_en & ~w_full;
   assign w_rd_acc = bus.rd_en & ~w_empty;

   assign bus.full    = w_full;
   assign bus.empty   = w_empty;
   assign bus.count   = r_wr_ptr - r_rd_ptr;
   assign bus.rd_data = r_rd_data;

   always_ff @(posedge clk)
      if (w_wr_acc) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_data <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH+1)'(1);
         if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_rd_ptr  <= r_rd_ptr + (ADDR_WIDTH+1)'(1);
         end
      end

`ifdef FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= bus.wr_en & w_full;
         r_underflow <= bus.rd_en & w_empty;
      end

   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (DEPTH = 16).
// Error-flag checks are compiled in when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

   sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [7:0] wd, input logic re);
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.rd_en   = re;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq [10];
      seq = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      #1;
      // Reset held for 5 cycles with toggling requests
      for (int i = 0; i < 5; i++) begin
         drive(i[0], 8'hFF, ~i[0]);
         step();
      end
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_count", 32'(bus.count), 0);
      drive(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      check("rel_empty", 32'(bus.empty), 1);
      check("rel_full", 32'(bus.full), 0);
      check("rel_count", 32'(bus.count), 0);
      check("rel_rd_data", 32'(bus.rd_data), 0);
      step();
      check("rel_nowrite", 32'(bus.count), 0);

      // Ordered transfer
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, seq[i], 1'b0);
         step();
         check("ord_wcount", 32'(bus.count), 32'(i + 1));
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         step();
         check("ord_rd_data", 32'(bus.rd_data), 32'(seq[i]));
      end
      drive(1'b0, 8'h00, 1'b0);
      check("ord_empty", 32'(bus.empty), 1);
      check("ord_count", 32'(bus.count), 0);

      // Full boundary: 17 writes, last one dropped
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         step();
         check("full_count", 32'(bus.count), (i < 16) ? 32'(i + 1) : 32'd16);
         check("full_flag", 32'(bus.full), (i >= 15) ? 32'd1 : 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
         check("overflow", 32'(bus.overflow), (i == 16) ? 32'd1 : 32'd0);
`endif
      end
      drive(1'b0, 8'h00, 1'b0);
      step();
`ifdef FIFO_ERR_FLAGS_EN
      check("overflow_clr", 32'(bus.overflow), 0);
`endif
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         step();
         check("full_rd_data", 32'(bus.rd_data), 32'(i));
      end
      check("full_drain_empty", 32'(bus.empty), 1);

      // Empty boundary: reads ignored, rd_data holds 0x0F
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         step();
         check("emp_rd_data", 32'(bus.rd_data), 32'h0F);
         check("emp_count", 32'(bus.count), 0);
`ifdef FIFO_ERR_FLAGS_EN
         check("underflow", 32'(bus.underflow), 1);
`endif
      end
      drive(1'b1, 8'hA5, 1'b0);
      step();
`ifdef FIFO_ERR_FLAGS_EN
      check("underflow_clr", 32'(bus.underflow), 0);
`endif
      check("emp_wr_count", 32'(bus.count), 1);
      drive(1'b0, 8'h00, 1'b1);
      step();
      check("emp_rd_a5", 32'(bus.rd_data), 32'hA5);

      // Simultaneous ops with count = 5 across pointer wrap
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(8'h30 + i), 1'b0);
         step();
      end
      check("sim_count5", 32'(bus.count), 5);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'(8'h35 + i), 1'b1);
         step();
         check("sim_rd_data", 32'(bus.rd_data), 32'(8'h30 + i));
         check("sim_count", 32'(bus.count), 5);
      end
      // Remaining 0x44..0x48; fill to full with 0x50..0x5A
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, 8'(8'h50 + i), 1'b0);
         step();
      end
      check("sim_full", 32'(bus.full), 1);
      drive(1'b1, 8'hEE, 1'b1);
      step();
      check("sim_full_count", 32'(bus.count), 15);
      check("sim_full_rd", 32'(bus.rd_data), 32'h44);
      check("sim_full_clr", 32'(bus.full), 0);
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         step();
      end
      drive(1'b0, 8'h00, 1'b0);
      check("mid_count8", 32'(bus.count), 8);
      check("mid_rd_data", 32'(bus.rd_data), 32'h52);

      // Mid-operation asynchronous reset pulse
      rst_n = 1'b0;
      #2;
      check("mid_rst_empty", 32'(bus.empty), 1);
      check("mid_rst_count", 32'(bus.count), 0);
      check("mid_rst_rd_data", 32'(bus.rd_data), 0);
      #3;
      rst_n = 1'b1;
      drive(1'b1, 8'h77, 1'b0);
      step();
      check("mid_wr_count", 32'(bus.count), 1);
      drive(1'b0, 8'h00, 1'b1);
      step();
      check("mid_rd_77", 32'(bus.rd_data), 32'h77);
      check("mid_end_empty", 32'(bus.empty), 1);
      drive(1'b0, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
